load_buffer_unit: RTL and testbench
===================================

// Module: load_buffer_unit
// PURPOSE
//  Consumer end of the LB_PACKET interface from address_calculation_unit.
//  Queues issued loads in order and performs one memory read at a time.
//  Extracts and extends the loaded byte, halfword or word.
//  Broadcasts the result on the CDB as an EX_WR_PACKET under an arbiter grant handshake.
//  Sits between execute and writeback, beside the ALU and multiplier CDB sources.
// PARAMETERS
//  DEPTH   4   load-queue entries (power of 2, >=2)
// PORTS
//  clock           in   1             system clock; all state updates on posedge
//  reset           in   1             asynchronous, active-high; clears all state
//  lb_packet_in    in   LB_PACKET     load from address unit; enqueued when .valid & ~lb_full
//  lb_full         out  1             count==DEPTH; upstream must not issue loads
//  lb_count        out  $clog2(DEPTH+1)  occupied entries, including the in-flight head
//  flush           in   1             branch-misprediction squash; discards every load
//  mem_req_valid   out  1             read request for the queue head
//  mem_req_ready   in   1             memory accepts the request in a cycle where valid&ready
//  mem_req_addr    out  XLEN          head address, word-aligned ({addr[XLEN-1:2],2'b00})
//  mem_resp_valid  in   1             read data returned (any latency >=1 after accept)
//  mem_resp_data   in   XLEN          full 32-bit word at mem_req_addr
//  cdb_out         out  EX_WR_PACKET  result: valid, value, rob_tag, inst, NPC
//  cdb_grant       in   1             arbiter accepts cdb_out this cycle
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, count=0, head/tail pointers=0, drop flag=0.
//   - lb_full=0, mem_req_valid=0, cdb_out all fields 0.
//  Queue:
//   - Circular FIFO with pointers wrapping at DEPTH.
//   - Entry fields: address, rd_tag, mem_size, inst, NPC.
//   - Enqueue when lb_packet_in.valid & ~lb_full & ~flush.
//   - lb_full comes from the registered count. When full, an enqueue is refused even if the head is popped in the same cycle.
//   - valid while full is dropped; an assertion fires.
//   - Enqueue and pop in the same cycle leave count unchanged.
//  FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
//   - IDLE: if count>0, go to REQ. An entry enqueued at edge N into an empty queue reaches REQ at edge N+1, so mem_req_valid is asserted in cycle N+1.
//   - REQ: mem_req_valid=1 with head address; hold it until mem_req_ready, then go to WAIT.
//   - WAIT: on mem_resp_valid, register the extracted value, set cdb_out.valid=1 from the next cycle, go to HOLD.
//   - HOLD: cdb_out is stable until cdb_grant. On a grant cycle, pop the head at the clock edge, clear cdb_out.valid, go to IDLE.
//   - Back-to-back loads therefore cost at least 4 cycles each.
//  Extraction (sh = addr[1:0]*8, w = mem_resp_data>>sh):
//   - funct3 000 LB: sext(w[7:0])
//   - funct3 001 LH: sext(w[15:0])
//   - funct3 010 LW: w
//   - funct3 100 LBU: zext(w[7:0])
//   - funct3 101 LHU: zext(w[15:0])
//   - Any other funct3: value 0, assertion.
//   - Misaligned LH/LW still apply the shift; an assertion fires.
//  cdb_out:
//   - rob_tag, inst and NPC come from the head entry.
//   - All fields are 0 whenever valid=0.
//  Flush (takes priority over every other event in the same cycle):
//   - Clear the queue (count=0, pointers=0) and drop any enqueue in that cycle.
//   - From IDLE, REQ (not yet accepted) or HOLD: go to IDLE; cdb_out.valid=0 and mem_req_valid=0 next cycle.
//   - If REQ is accepted in the flush cycle, or state is WAIT: go to DRAIN. The outstanding response is discarded, then go to IDLE.
//   - mem_resp_valid in the flush cycle itself counts as consumed; go to IDLE.
//   - While in DRAIN, new loads may enqueue but no request is issued until IDLE.
//   - A grant in the flush cycle is ignored and produces no pop.
//  Reset mid-operation: immediate return to the reset state. An outstanding memory response after reset is the memory's responsibility; this block ignores it in IDLE.
// TESTING
//  1. LW addr 0x100, tag 3; mem_req_ready=1; data 0xDEADBEEF 2 cycles later; grant at once -> mem_req_addr=0x100, cdb_out{valid,value=0xDEADBEEF,rob_tag=3}, count back to 0.
//  2. LB addr 0x103 and LBU addr 0x103, data 0x80112233 -> values 0xFFFFFF80 then 0x00000080, in order; LH/LHU at 0x102 -> 0xFFFF8011 / 0x00008011.
//  3. Enqueue 4 loads, memory stalled -> lb_full=1, lb_count=4; a 5th valid is not accepted; after one grant lb_full=0 the next cycle; all 4 tags exit in FIFO order.
//  4. cdb_grant held 0 for 5 cycles -> cdb_out identical every cycle; no second mem request until the cycle after grant.
//  5. flush in WAIT with 2 queued -> count=0 next cycle; late mem_resp 0x1234 yields no CDB output; a new load then completes normally.
//  6. reset asserted in HOLD mid-cycle -> cdb_out.valid=0 and mem_req_valid=0 immediately (async), lb_count=0.

Source files
------------

// File: rtl/load_buffer_unit.sv
// In-order load queue: one outstanding memory read, extracted result broadcast on the CDB.
// Latency: enqueue->mem_req_valid 2 cycles, response->cdb_out.valid 1 cycle, >=4 cycles per load.
// Backpressure: lb_full stalls upstream; request held until mem_req_ready; result held until cdb_grant.
module load_buffer_unit #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [104:0]               lb_packet_in,
  output logic                       lb_full,
  output logic [$clog2(DEPTH+1)-1:0] lb_count,
  input  logic                       flush,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_data,
  output logic [101:0]               cdb_out,
  input  logic                       cdb_grant
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [4:0]  rd_tag;
    logic [2:0]  mem_size;
    logic [31:0] inst;
    logic [31:0] npc;
  } lb_packet_t;

  typedef struct packed {
    logic [31:0] address;
    logic [4:0]  rd_tag;
    logic [2:0]  mem_size;
    logic [31:0] inst;
    logic [31:0] npc;
  } lb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [4:0]  rob_tag;
    logic [31:0] inst;
    logic [31:0] npc;
  } ex_wr_packet_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  lb_packet_t    lb_in;
  lb_entry_t     queue_mem [DEPTH];
  lb_entry_t     head_e;
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [CW-1:0] count;
  state_t        state, state_nxt;
  ex_wr_packet_t cdb_q, cdb_nxt;
  logic          enq, pop;
  logic [31:0]   resp_word, load_value;

  assign lb_in   = lb_packet_in;
  assign head_e  = queue_mem[head_ptr];
  assign lb_full = (count == CW'(DEPTH));
  assign enq     = lb_in.valid & ~lb_full & ~flush;
  assign pop     = (state == HOLD) & cdb_grant & ~flush;

  assign lb_count      = count;
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = mem_req_valid ? {head_e.address[31:2], 2'b00} : 32'h0;
  assign cdb_out       = cdb_q;

  // Shift the addressed byte lane down to bit 0 before size extension.
  assign resp_word = mem_resp_data >> {head_e.address[1:0], 3'b000};

  always_comb begin
    load_value = '0;
    case (head_e.mem_size)
      3'b000:  load_value = {{24{resp_word[7]}}, resp_word[7:0]};
      3'b001:  load_value = {{16{resp_word[15]}}, resp_word[15:0]};
      3'b010:  load_value = resp_word;
      3'b100:  load_value = {24'h0, resp_word[7:0]};
      3'b101:  load_value = {16'h0, resp_word[15:0]};
      default: load_value = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cdb_nxt   = cdb_q;
    case (state)
      IDLE: if (!flush && count != '0) state_nxt = REQ;
      REQ: begin
        // An accepted request leaves a response in flight that must be drained.
        if (flush)              state_nxt = mem_req_ready ? DRAIN : IDLE;
        else if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_nxt = mem_resp_valid ? IDLE : DRAIN;
        end else if (mem_resp_valid) begin
          state_nxt       = HOLD;
          cdb_nxt.valid   = 1'b1;
          cdb_nxt.value   = load_value;
          cdb_nxt.rob_tag = head_e.rd_tag;
          cdb_nxt.inst    = head_e.inst;
          cdb_nxt.npc     = head_e.npc;
        end
      end
      HOLD: begin
        if (flush || cdb_grant) begin
          state_nxt = IDLE;
          cdb_nxt   = '0;
        end
      end
      DRAIN:   if (mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cdb_q    <= '0;
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      state <= state_nxt;
      cdb_q <= cdb_nxt;
      if (flush) begin
        count    <= '0;
        head_ptr <= '0;
        tail_ptr <= '0;
      end else begin
        if (enq) tail_ptr <= tail_ptr + PW'(1);
        if (pop) head_ptr <= head_ptr + PW'(1);
        count <= count + CW'(enq) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (enq) queue_mem[tail_ptr] <= {lb_in.address, lb_in.rd_tag, lb_in.mem_size, lb_in.inst, lb_in.npc};
  end

  a_drop_when_full: assert property (@(posedge clock) disable iff (reset)
    !(lb_in.valid && lb_full))
    else $warning("load_buffer_unit: load dropped, queue full");

  a_bad_size: assert property (@(posedge clock) disable iff (reset)
    (state == WAIT && mem_resp_valid && !flush) |->
      (head_e.mem_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
    else $error("load_buffer_unit: unsupported load size");

  a_misaligned: assert property (@(posedge clock) disable iff (reset)
    (state == WAIT && mem_resp_valid && !flush) |->
      !((head_e.mem_size[1:0] == 2'b01 && head_e.address[0]) ||
        (head_e.mem_size[1:0] == 2'b10 && head_e.address[1:0] != 2'b00)))
    else $error("load_buffer_unit: misaligned load");

endmodule

// File: tb/tb_load_buffer_unit.sv
// Self-checking bench for load_buffer_unit: transaction-level reference model plus directed cases.
module tb_load_buffer_unit;
  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [104:0] lb_packet_in;
  logic         lb_full;
  logic [2:0]   lb_count;
  logic         flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic [101:0] cdb_out;
  logic         cdb_grant;

  always #5 clock = ~clock;

  load_buffer_unit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .lb_packet_in(lb_packet_in), .lb_full(lb_full),
    .lb_count(lb_count), .flush(flush), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cdb_out(cdb_out), .cdb_grant(cdb_grant)
  );

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  tag;
    logic [2:0]  f;
    logic [31:0] inst;
    logic [31:0] npc;
  } rec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: list of queued loads plus where the head load is in its life.
  rec_t         mq[$];
  bit           m_req, m_wait, m_hold, m_stale;
  logic [101:0] m_cdb;
  bit           chk_en = 0;
  bit           cur_v;
  rec_t         cur;

  // Memory environment: one outstanding response, fixed or random latency.
  int           resp_wait = 0;
  int           lat_fix = 0;
  logic [31:0]  data_q[$];
  bit           hs;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w = d >> (8 * int'(a[1:0]));
    int b = int'(w & 32'hFF);
    int h = int'(w & 32'hFFFF);
    case (f)
      3'b000:  return 32'(b >= 128 ? b - 256 : b);
      3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
      3'b010:  return w;
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic rec_t mk(input logic [31:0] a, input logic [4:0] t, input logic [2:0] f);
    rec_t r;
    r.addr = a; r.tag = t; r.f = f; r.inst = $urandom; r.npc = a + 32'h1000;
    return r;
  endfunction

  task automatic drive_load(input bit v, input rec_t r);
    cur_v = v;
    cur = r;
    lb_packet_in = {v, r.addr, r.tag, r.f, r.inst, r.npc};
  endtask

  task automatic model_clear();
    mq.delete();
    m_req = 0; m_wait = 0; m_hold = 0; m_stale = 0; m_cdb = '0;
  endtask

  task automatic model_update();
    bit was_idle = !(m_req || m_wait || m_hold || m_stale);
    int sz = mq.size();
    if (flush) begin
      m_stale = (m_stale && !mem_resp_valid) || (m_req && mem_req_ready) ||
                (m_wait && !mem_resp_valid);
      m_req = 0; m_wait = 0; m_hold = 0; m_cdb = '0;
      mq.delete();
    end else begin
      if (m_stale && mem_resp_valid) m_stale = 0;
      else if (m_req && mem_req_ready) begin m_req = 0; m_wait = 1; end
      else if (m_wait && mem_resp_valid) begin
        m_wait = 0; m_hold = 1;
        m_cdb = {1'b1, ext(mq[0].f, mq[0].addr, mem_resp_data), mq[0].tag, mq[0].inst, mq[0].npc};
      end else if (m_hold && cdb_grant) begin
        m_hold = 0; m_cdb = '0;
        void'(mq.pop_front());
      end else if (was_idle && sz > 0) m_req = 1;
      if (cur_v && sz < DEPTH) mq.push_back(cur);
    end
  endtask

  task automatic respond();
    mem_resp_valid = 0;
    if (hs) resp_wait = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        mem_resp_valid = 1;
        mem_resp_data = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    hs = mem_req_valid && mem_req_ready;
    @(posedge clock);
    model_update();
    #1;
    respond();
  endtask

  task automatic wait_cdb(input string name, output logic [101:0] c);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cdb_out[101]) ok = 1;
      else tick();
    end
    if (!ok) timeout(name);
    c = cdb_out;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("lb_count", lb_count, mq.size());
      chk("lb_full", lb_full, mq.size() == DEPTH);
      chk("mem_req_valid", mem_req_valid, m_req);
      if (m_req) chk("mem_req_addr", mem_req_addr, {mq[0].addr[31:2], 2'b00});
      chk("cdb_out", cdb_out, m_cdb);
    end
  end

  logic [101:0] c, c0;
  logic [31:0]  t2_exp [4];
  logic [2:0]   sizes [5];
  rec_t         idle_r;

  initial begin
    t2_exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    idle_r = mk(32'h0, 5'd0, 3'b010);
    reset = 1; flush = 0; mem_req_ready = 0; cdb_grant = 0;
    mem_resp_valid = 0; mem_resp_data = 0;
    drive_load(0, idle_r);
    model_clear();
    @(posedge clock); #1;
    chk("reset lb_count", lb_count, 0);
    chk("reset lb_full", lb_full, 0);
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset cdb_out", cdb_out, 0);
    @(posedge clock); #1;
    reset = 0;
    chk_en = 1;

    // 1: single LW
    cdb_grant = 1; mem_req_ready = 1; lat_fix = 2;
    data_q.push_back(32'hDEADBEEF);
    drive_load(1, mk(32'h100, 5'd3, 3'b010)); tick(); drive_load(0, idle_r);
    chk("t1 count after enqueue", lb_count, 1);
    chk("t1 no request yet", mem_req_valid, 0);
    tick();
    chk("t1 request valid", mem_req_valid, 1);
    chk("t1 request addr", mem_req_addr, 32'h100);
    wait_cdb("t1 cdb", c);
    chk("t1 cdb valid", c[101], 1);
    chk("t1 cdb value", c[100:69], 32'hDEADBEEF);
    chk("t1 cdb tag", c[68:64], 3);
    tick();
    chk("t1 count drained", lb_count, 0);
    chk("t1 cdb cleared", cdb_out[101], 0);

    // 2: byte / halfword extraction, in order
    lat_fix = 1;
    repeat (4) data_q.push_back(32'h80112233);
    drive_load(1, mk(32'h103, 5'd20, 3'b000)); tick();
    drive_load(1, mk(32'h103, 5'd21, 3'b100)); tick();
    drive_load(1, mk(32'h102, 5'd22, 3'b001)); tick();
    drive_load(1, mk(32'h102, 5'd23, 3'b101)); tick();
    drive_load(0, idle_r);
    for (int k = 0; k < 4; k++) begin
      wait_cdb("t2 cdb", c);
      chk("t2 value", c[100:69], t2_exp[k]);
      chk("t2 tag", c[68:64], 20 + k);
      tick();
    end

    // 3/4: fill, overflow attempt, held grant, FIFO order
    mem_req_ready = 0; cdb_grant = 0;
    for (int k = 0; k < 4; k++) begin
      drive_load(1, mk(32'h200 + 32'(4 * k), 5'(10 + k), 3'b010)); tick();
    end
    drive_load(0, idle_r);
    chk("t3 full", lb_full, 1);
    chk("t3 count", lb_count, 4);
    drive_load(1, mk(32'h300, 5'd14, 3'b010)); tick(); drive_load(0, idle_r);
    chk("t3 fifth refused", lb_count, 4);
    mem_req_ready = 1;
    wait_cdb("t3 cdb", c0);
    chk("t3 first tag", c0[68:64], 10);
    chk("t3 still full", lb_full, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4 cdb stable", cdb_out, c0);
      chk("t4 no request", mem_req_valid, 0);
    end
    cdb_grant = 1; tick();
    chk("t3 not full after grant", lb_full, 0);
    chk("t3 count after grant", lb_count, 3);
    chk("t4 no request in grant+1", mem_req_valid, 0);
    tick();
    chk("t4 next request", mem_req_valid, 1);
    chk("t4 next addr", mem_req_addr, 32'h204);
    for (int k = 1; k < 4; k++) begin
      wait_cdb("t3 cdb", c);
      chk("t3 fifo tag", c[68:64], 10 + k);
      tick();
    end

    // 5: flush while waiting for data
    cdb_grant = 0; lat_fix = 4;
    data_q.push_back(32'h1234);
    drive_load(1, mk(32'h40, 5'd1, 3'b010)); tick();
    drive_load(1, mk(32'h44, 5'd2, 3'b010)); tick();
    drive_load(0, idle_r);
    for (int k = 0; k < 20 && resp_wait == 0; k++) tick();
    if (resp_wait == 0) timeout("t5 request");
    flush = 1; tick(); flush = 0;
    chk("t5 count flushed", lb_count, 0);
    chk("t5 no request", mem_req_valid, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5 late resp ignored", cdb_out[101], 0);
    end
    cdb_grant = 1; lat_fix = 1;
    data_q.push_back(32'hCAFEF00D);
    drive_load(1, mk(32'h48, 5'd7, 3'b010)); tick(); drive_load(0, idle_r);
    wait_cdb("t5 cdb", c);
    chk("t5 new value", c[100:69], 32'hCAFEF00D);
    chk("t5 new tag", c[68:64], 7);
    tick();

    // 6: async reset while holding a result
    cdb_grant = 0;
    drive_load(1, mk(32'h80, 5'd9, 3'b010)); tick(); drive_load(0, idle_r);
    wait_cdb("t6 cdb", c);
    @(posedge clock); #3;
    reset = 1;
    model_clear(); resp_wait = 0; data_q.delete(); mem_resp_valid = 0;
    #1;
    chk("t6 cdb valid after reset", cdb_out[101], 0);
    chk("t6 mem_req_valid after reset", mem_req_valid, 0);
    chk("t6 lb_count after reset", lb_count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // Random traffic
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  f = sizes[$urandom_range(0, 4)];
      logic [31:0] a = $urandom;
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      drive_load(($urandom_range(0, 1) == 1) && (mq.size() < DEPTH), mk(a, 5'($urandom), f));
      flush = ($urandom_range(0, 29) == 0);
      mem_req_ready = 1'($urandom_range(0, 1));
      cdb_grant = 1'($urandom_range(0, 1));
      tick();
    end
    drive_load(0, idle_r); flush = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
